data_sram_arb: RTL and testbench

- Two-requester arbiter/sequencer in front of the 256x8 data SRAM.
- The SRAM acts only on the falling edge of CS_D, writing if WD=1, else reading if RD=1, with DOUT registered at that edge.
- This block serialises CPU (port A) and DMA/debug (port B) accesses into clean SETUP/STROBE/DONE sequences on that strobe interface.
- It returns read data and a one-cycle ACK to the granted requester.

---
 rtl/data_sram_arb_pkg.sv | 16 +
 rtl/data_sram_arb_rr_arb2.sv | 35 +++
 rtl/data_sram_arb.sv | 123 ++++++++++++
 tb/tb_data_sram_arb.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_arb_pkg.sv
// data_sram_arb_pkg
//   Shared definitions for the data SRAM arbiter: the sequencer state
//   encoding and the port-select values used by the arbiter and the top.
package data_sram_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/data_sram_arb_rr_arb2.sv
// rr_arb2
//   Two-input round-robin arbiter with a last-grant register.
//   Ports:
//     clk, rst  clock, async active-high reset
//     req[1:0]  request pair, bit 0 = port A, bit 1 = port B
//     en        grant enable; last-grant only moves when en is high
//     grant     one-hot grant (combinational from req and last-grant)
module rr_arb2
    import data_sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    logic last;

    // A lone request always wins; on a tie, the port not served last wins.
    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = (last == PORT_B) ? 2'b01 : 2'b10;
    end

    // Reset to B so that A wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= PORT_B;
        else if (en && |req)
            last <= grant[1];
    end

endmodule

// File: rtl/data_sram_arb.sv
// data_sram_arb
//   Serialises port A (CPU) and port B (DMA/debug) accesses to the 256x8
//   data SRAM as IDLE -> SETUP -> STROBE -> DONE sequences. The SRAM acts on
//   the falling edge of CS_D, so the bus (ADDR/DIN/WD/RD) is set up one full
//   cycle before CS_D drops and CS_D is low for exactly one cycle.
//   Ports:
//     CLK, RST                     clock, async active-high reset
//     x_REQ/x_WE/x_ADDR/x_WDATA    port request (x = A, B), sampled at grant
//     x_ACK, x_RDATA               one-cycle completion pulse, read data
//     BUSY                         high whenever not IDLE
//     CS_D, WD, RD, DIN, ADDR      SRAM strobe interface (all registered)
//     DOUT                         SRAM read data, valid after CS_D falls
module data_sram_arb
    import data_sram_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              A_REQ,
    input  logic              A_WE,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_WDATA,
    output logic              A_ACK,
    output logic [DATA_W-1:0] A_RDATA,
    input  logic              B_REQ,
    input  logic              B_WE,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_WDATA,
    output logic              B_ACK,
    output logic [DATA_W-1:0] B_RDATA,
    output logic              BUSY,
    output logic              CS_D,
    output logic              WD,
    output logic              RD,
    output logic [DATA_W-1:0] DIN,
    output logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DOUT
);

    state_t     state;
    logic       sel;      // port owning the access in flight
    logic [1:0] grant;
    logic       grant_en;

    // Requests are only looked at in IDLE; the other port waits there.
    assign grant_en = (state == S_IDLE);

    rr_arb2 u_arb (
        .clk   (CLK),
        .rst   (RST),
        .req   ({B_REQ, A_REQ}),
        .en    (grant_en),
        .grant (grant)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            sel     <= PORT_A;
            CS_D    <= 1'b1;
            WD      <= 1'b0;
            RD      <= 1'b0;
            DIN     <= '0;
            ADDR    <= '0;
            A_ACK   <= 1'b0;
            B_ACK   <= 1'b0;
            A_RDATA <= '0;
            B_RDATA <= '0;
            BUSY    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|grant) begin
                        // Latch the winner's request so later input changes
                        // cannot disturb the access.
                        sel <= grant[1];
                        if (grant[1]) begin
                            ADDR <= B_ADDR;
                            DIN  <= B_WDATA;
                            WD   <= B_WE;
                            RD   <= ~B_WE;
                        end else begin
                            ADDR <= A_ADDR;
                            DIN  <= A_WDATA;
                            WD   <= A_WE;
                            RD   <= ~A_WE;
                        end
                        BUSY  <= 1'b1;
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    CS_D  <= 1'b0;
                    state <= S_STROBE;
                end
                S_STROBE: begin
                    // DOUT was registered by the SRAM when CS_D fell.
                    CS_D <= 1'b1;
                    WD   <= 1'b0;
                    RD   <= 1'b0;
                    if (sel == PORT_B) begin
                        B_ACK <= 1'b1;
                        if (RD) B_RDATA <= DOUT;
                    end else begin
                        A_ACK <= 1'b1;
                        if (RD) A_RDATA <= DOUT;
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    A_ACK <= 1'b0;
                    B_ACK <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_arb.sv
// tb_data_sram_arb
//   Scoreboard bench: each access is pushed to a queue in the order the bench
//   expects it to be served; the strobe monitor checks the bus against the
//   queue head and the ACK monitor pops and checks port and read data.
module tb_data_sram_arb;

    logic       CLK = 1'b0;
    logic       RST;
    logic       A_REQ, A_WE, B_REQ, B_WE;
    logic [7:0] A_ADDR, A_WDATA, B_ADDR, B_WDATA;
    logic       A_ACK, B_ACK, BUSY, CS_D, WD, RD;
    logic [7:0] A_RDATA, B_RDATA, DIN, ADDR, DOUT;

    always #5 CLK = ~CLK;

    data_sram_arb #(.ADDR_W(8), .DATA_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
        .A_ACK(A_ACK), .A_RDATA(A_RDATA),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
        .B_ACK(B_ACK), .B_RDATA(B_RDATA),
        .BUSY(BUSY), .CS_D(CS_D), .WD(WD), .RD(RD), .DIN(DIN), .ADDR(ADDR),
        .DOUT(DOUT)
    );

    typedef struct {
        bit         port;   // 0 = A, 1 = B
        bit         we;
        logic [7:0] addr;
        logic [7:0] data;   // write data, or expected read data
    } txn_t;

    txn_t       q[$];
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] sh_a, sh_b;     // expected RDATA registers
    bit         last_b;         // bench's own round-robin history
    int         checks = 0, errors = 0;
    int         cs_low = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // SRAM model: acts only on the falling edge of CS_D.
    always @(negedge CS_D) begin
        if (RST !== 1'b1) begin
            chk("wd_rd_excl", 32'(WD ^ RD), 1);
            if (q.size() == 0)
                chk("strobe_unexpected", 1, 0);
            else begin
                chk("strobe_addr", 32'(ADDR), 32'(q[0].addr));
                chk("strobe_we", 32'(WD), 32'(q[0].we));
                if (q[0].we) chk("strobe_din", 32'(DIN), 32'(q[0].data));
            end
            if (WD) mem[ADDR] = DIN;
            else if (RD) DOUT = mem[ADDR];
        end
    end

    // CS_D low width and ACK scoreboard, sampled mid-cycle.
    always @(negedge CLK) begin
        txn_t t;
        if (CS_D === 1'b0) cs_low++;
        else if (cs_low != 0) begin
            chk("cs_low_width", cs_low, 1);
            cs_low = 0;
        end
        if (A_ACK === 1'b1 || B_ACK === 1'b1) begin
            chk("ack_onehot", 32'(A_ACK & B_ACK), 0);
            if (q.size() == 0)
                chk("ack_unexpected", 1, 0);
            else begin
                t = q.pop_front();
                chk("ack_port", 32'(B_ACK), 32'(t.port));
                if (!t.we) begin
                    if (t.port) sh_b = t.data;
                    else        sh_a = t.data;
                end
                chk("rdata_a", 32'(A_RDATA), 32'(sh_a));
                chk("rdata_b", 32'(B_RDATA), 32'(sh_b));
            end
        end
    end

    task automatic push(input bit port, input bit we, input logic [7:0] addr, input logic [7:0] data);
        txn_t t;
        t.port = port;
        t.we   = we;
        t.addr = addr;
        t.data = we ? data : ref_mem[addr];
        if (we) ref_mem[addr] = data;
        last_b = port;
        q.push_back(t);
    endtask

    // One access per enabled port; chg moves A_ADDR once the access is granted.
    task automatic xfer(input bit a_en, input bit a_we, input logic [7:0] a_addr, input logic [7:0] a_data,
                        input bit b_en, input bit b_we, input logic [7:0] b_addr, input logic [7:0] b_data,
                        input bit chg);
        int n = 0;
        int acks = 0;
        bit a_first;
        a_first = a_en && (!b_en || last_b);
        if (a_first) begin
            push(0, a_we, a_addr, a_data);
            if (b_en) push(1, b_we, b_addr, b_data);
        end else begin
            push(1, b_we, b_addr, b_data);
            if (a_en) push(0, a_we, a_addr, a_data);
        end
        @(negedge CLK);
        A_REQ = a_en; A_WE = a_we; A_ADDR = a_addr; A_WDATA = a_data;
        B_REQ = b_en; B_WE = b_we; B_ADDR = b_addr; B_WDATA = b_data;
        while ((A_REQ || B_REQ) && n < 20) begin
            @(negedge CLK);
            n++;
            if (n == 1) chk("busy_setup", 32'(BUSY), 1);
            if (n == 1 && chg) A_ADDR = A_ADDR + 8'd1;
            if (A_ACK || B_ACK) begin
                // first ACK 3 edges after the request cycle, next one 4 later
                chk("ack_lat", n, (acks == 0) ? 3 : 7);
                acks++;
                if (A_ACK) A_REQ = 1'b0;
                if (B_ACK) B_REQ = 1'b0;
            end
        end
        if (n >= 20) chk("ack_timeout", 0, 1);
        @(negedge CLK);
        chk("busy_idle", 32'(BUSY), 0);
        if (chg) chk("addr_hold", 32'(ADDR), 32'(a_addr));
    endtask

    // B holds REQ through three reads, moving B_ADDR on each ACK.
    task automatic b_stream(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
        logic [7:0] ad [3];
        int n = 0, k = 0, prev = 0;
        ad[0] = a0; ad[1] = a1; ad[2] = a2;
        for (int i = 0; i < 3; i++) push(1, 0, ad[i], 8'h00);
        @(negedge CLK);
        B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = ad[0];
        while (k < 3 && n < 40) begin
            @(negedge CLK);
            n++;
            if (B_ACK) begin
                if (k > 0) chk("b2b_spacing", n - prev, 4);
                prev = n;
                k++;
                if (k < 3) B_ADDR = ad[k];
                else       B_REQ = 1'b0;
            end
        end
        if (k < 3) chk("b2b_timeout", k, 3);
        @(negedge CLK);
    endtask

    // Port A access cut by reset after 'stage' edges (1 = SETUP, 2 = STROBE).
    task automatic rst_mid(input int stage, input logic [7:0] addr, input logic [7:0] data);
        if (stage == 2) push(0, 1, addr, data);  // strobe already issued
        @(negedge CLK);
        A_REQ = 1'b1; A_WE = 1'b1; A_ADDR = addr; A_WDATA = data;
        repeat (stage) @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("rst_cs_d", 32'(CS_D), 1);
        chk("rst_wd", 32'(WD), 0);
        chk("rst_rd", 32'(RD), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_ack", 32'({A_ACK, B_ACK}), 0);
        q.delete();
        sh_a = 8'h00; sh_b = 8'h00;
        last_b = 1'b1;
        A_REQ = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b0;
        A_REQ = 0; A_WE = 0; A_ADDR = 0; A_WDATA = 0;
        B_REQ = 0; B_WE = 0; B_ADDR = 0; B_WDATA = 0;
        DOUT = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        sh_a = 8'h00; sh_b = 8'h00; last_b = 1'b1;
        #1 RST = 1'b1;
        #2;
        chk("reset_cs_d", 32'(CS_D), 1);
        chk("reset_wd_rd", 32'({WD, RD}), 0);
        chk("reset_din", 32'(DIN), 0);
        chk("reset_addr", 32'(ADDR), 0);
        chk("reset_ack", 32'({A_ACK, B_ACK}), 0);
        chk("reset_rdata", 32'({A_RDATA, B_RDATA}), 0);
        chk("reset_busy", 32'(BUSY), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // A write then read
        xfer(1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00, 0);
        xfer(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        // A served last, so B wins the tie
        xfer(1, 0, 8'h10, 8'h00, 1, 1, 8'hFF, 8'h33, 0);
        xfer(0, 0, 8'h00, 8'h00, 1, 0, 8'hFF, 8'h00, 0);
        // B served last, so A wins the tie
        xfer(1, 1, 8'h01, 8'h22, 1, 1, 8'h00, 8'h11, 0);
        // held REQ stream
        b_stream(8'h10, 8'hFF, 8'h01);
        // port isolation; the write must leave A_RDATA alone
        xfer(1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        xfer(0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0);
        xfer(1, 1, 8'h02, 8'h77, 0, 0, 8'h00, 8'h00, 0);
        chk("iso_a_after_write", 32'(A_RDATA), 32'h22);
        chk("iso_b", 32'(B_RDATA), 32'h11);
        // address change after grant
        xfer(1, 1, 8'h20, 8'h44, 0, 0, 8'h00, 8'h00, 0);
        xfer(1, 1, 8'h21, 8'h99, 0, 0, 8'h00, 8'h00, 0);
        xfer(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 1);
        // reset in STROBE (write lands) and in SETUP (write must not land)
        rst_mid(2, 8'h30, 8'hEE);
        rst_mid(1, 8'h31, 8'hDD);
        // arbitration restarts with A preferred
        xfer(1, 0, 8'h30, 8'h00, 1, 0, 8'h31, 8'h00, 0);
        chk("mem_0x31_untouched", 32'(mem[8'h31]), 0);
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
